// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-conversion arbiter: FSM state encoding,
// default sizing and the binary-to-Gray conversion function.
package gray_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int GRAY_MAX_W  = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Operands narrower than GRAY_MAX_W are zero-extended by the caller, so the
  // MSB of the truncated result equals the binary MSB as required.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after rr_ptr, wrapping around, and reports it one-hot and encoded.
import gray_pkg::*;

module rr_arbiter #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  function automatic int wrap_idx(input int v);
    return (v >= NUM_REQ) ? (v - NUM_REQ) : v;
  endfunction

  logic found_s;

  // Cyclic priority search starting at rr_ptr; the first hit wins.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    found_s   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found_s && req[wrap_idx(int'(rr_ptr) + off)]) begin
        found_s = 1'b1;
        grant[wrap_idx(int'(rr_ptr) + off)] = 1'b1;
        grant_idx = ID_W'(wrap_idx(int'(rr_ptr) + off));
      end else begin
        found_s = found_s;
      end
    end
    grant_valid = found_s;
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary-to-Gray converter with a single registered,
// ID-tagged output slot that can be drained and refilled in the same cycle.
import gray_pkg::*;

module gray_conv_arbiter #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_valid_s;
  logic               can_accept_s;
  logic               accept_s;
  logic [WIDTH-1:0]   sel_data_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Handshake qualification; rst_n gates ready so nothing is offered in reset.
  always_comb begin
    can_accept_s = (state_q == ST_EMPTY) || (out_ready && (state_q == ST_FULL));
    req_ready    = grant_s & {NUM_REQ{can_accept_s & rst_n}};
    accept_s     = grant_valid_s && can_accept_s && rst_n;
    sel_data_s   = req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
  end

  // Next-state logic for the output slot.
  always_comb begin
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = ST_FULL;
        else          state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept_s)       state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
        else                state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Slot payload and round-robin pointer update on an accepted request.
  always_comb begin
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept_s) begin
      out_data_d = WIDTH'(bin2gray(GRAY_MAX_W'(sel_data_s)));
      out_id_d   = grant_idx_s;
      if (grant_idx_s == ID_W'(NUM_REQ - 1)) rr_ptr_d = {ID_W{1'b0}};
      else                                   rr_ptr_d = grant_idx_s + ID_W'(1);
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= {ID_W{1'b0}};
      out_data_q <= {WIDTH{1'b0}};
      out_id_q   <= {ID_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = out_data_q;
    out_id    = out_id_q;
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed, table-driven bench for gray_conv_arbiter (NUM_REQ=4, WIDTH=4)
// with hand-written sequences for async reset, fairness wrap and drain.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        ordy;
    logic [3:0]  erdy;
    logic        eov;
    logic [3:0]  eod;
    logic [1:0]  eid;
  } vec_t;

  vec_t tbl[18];
  logic [3:0] exp_all[4];

  gray_conv_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            rv       rd        ordy  erdy     eov   eod      eid
    tbl[0]  = '{4'b0001, 16'h000B, 1'b1, 4'b0001, 1'b1, 4'b1110, 2'd0};
    tbl[1]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b1110, 2'd0};
    tbl[2]  = '{4'b1111, 16'h8F70, 1'b1, 4'b0010, 1'b1, 4'b0100, 2'd1};
    tbl[3]  = '{4'b1111, 16'h8F70, 1'b1, 4'b0100, 1'b1, 4'b1000, 2'd2};
    tbl[4]  = '{4'b1111, 16'h8F70, 1'b1, 4'b1000, 1'b1, 4'b1100, 2'd3};
    tbl[5]  = '{4'b1111, 16'h8F70, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0};
    tbl[6]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tbl[7]  = '{4'b0100, 16'h0700, 1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2};
    tbl[8]  = '{4'b0001, 16'h000B, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2};
    tbl[9]  = '{4'b0001, 16'h000B, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2};
    tbl[10] = '{4'b0001, 16'h000B, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2};
    tbl[11] = '{4'b0001, 16'h000B, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2};
    tbl[12] = '{4'b0001, 16'h000B, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2};
    tbl[13] = '{4'b0001, 16'h000B, 1'b1, 4'b0001, 1'b1, 4'b1110, 2'd0};
    tbl[14] = '{4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b1, 4'b0010, 2'd2};
    tbl[15] = '{4'b0110, 16'h0350, 1'b1, 4'b0010, 1'b1, 4'b0111, 2'd1};
    tbl[16] = '{4'b0110, 16'h0350, 1'b1, 4'b0100, 1'b1, 4'b0010, 2'd2};
    tbl[17] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd2};

    exp_all[0] = 4'b0000;
    exp_all[1] = 4'b0100;
    exp_all[2] = 4'b1000;
    exp_all[3] = 4'b1100;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_out_id",    32'(out_id),    32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].rv;
      req_data  = tbl[i].rd;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].eod));
      chk($sformatf("vec%0d_out_id", i),    32'(out_id),    32'(tbl[i].eid));
    end

    // Asynchronous reset between edges while the slot is full.
    req_valid = 4'b1111;
    req_data  = 16'h8F70;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data",  32'(out_data),  32'd0);
    chk("async_rst_out_id",    32'(out_id),    32'd0);
    chk("async_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Fairness from rr_ptr=0 with all four requesters valid.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair%0d_req_ready", i), 32'(req_ready), 32'(4'b0001 << i));
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("fair%0d_out_data", i),  32'(out_data),  32'(exp_all[i]));
      chk($sformatf("fair%0d_out_id", i),    32'(out_id),    32'(i));
    end
    chk("wrap_req_ready", 32'(req_ready), 32'(4'b0001));

    // Drain with nothing pending: slot empties, payload retained.
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    #1;
    chk("drain_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data",  32'(out_data),  32'(4'b1100));
    chk("drain_out_id",    32'(out_id),    32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
